aes_stream_scheduler: RTL and testbench

- Controller that sequences the AES-128 sequential key expansion and the 11-stage pipelined encryption datapath, both of which sit beside it.
- Accepts plaintext blocks on a valid/ready stream and issues them to the non-stallable pipeline.
- Uses credit-based admission so that every in-flight result has a guaranteed slot in an internal output FIFO, which then drains on a valid/ready output stream.
- Owns key reload: stops admission, drains the pipeline, then re-runs key expansion.

---
 rtl/aes_stream_scheduler_if.sv | 36 +++
 rtl/aes_stream_scheduler.sv | 125 ++++++++++++
 tb/tb_aes_stream_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_scheduler_if.sv
// Handshake bundle between the AES stream scheduler and its surroundings:
// key control, plaintext/ciphertext streams, pipeline link and status.
interface aes_stream_scheduler_if #(
    parameter int CNT_W = 32
);
    logic             key_load;
    logic             kexp_start;
    logic             kexp_ready;
    logic             s_valid;
    logic             s_ready;
    logic [127:0]     s_data;
    logic             enc_valid;
    logic [127:0]     enc_data;
    logic             enc_done;
    logic [127:0]     enc_out;
    logic             m_valid;
    logic             m_ready;
    logic [127:0]     m_data;
    logic             busy;
    logic [CNT_W-1:0] blk_count;
    logic             err;

    modport master (
        input  key_load, kexp_ready, s_valid, s_data,
        input  enc_done, enc_out, m_ready,
        output kexp_start, s_ready, enc_valid, enc_data,
        output m_valid, m_data, busy, blk_count, err
    );

    modport slave (
        output key_load, kexp_ready, s_valid, s_data,
        output enc_done, enc_out, m_ready,
        input  kexp_start, s_ready, enc_valid, enc_data,
        input  m_valid, m_data, busy, blk_count, err
    );
endinterface

// File: rtl/aes_stream_scheduler.sv
// Sequences AES-128 key expansion and the 11-stage encrypt pipeline;
// credit admission guarantees every in-flight block an output FIFO slot.
module aes_stream_scheduler #(
    parameter int PIPE_LAT = 11,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 32
) (
    input logic                    clk,
    input logic                    reset_n,
    aes_stream_scheduler_if.master io
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (DEPTH > PIPE_LAT) ? DEPTH : PIPE_LAT;
    localparam int FW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, KEY_CLR, KEY_WAIT, RUN, DRAIN
    } state_t;

    state_t         state, state_nx;
    logic           pending, pending_nx;
    logic           kexp_start_nx;
    logic [FW-1:0]  fifo_count, in_flight;
    logic [FW:0]    occ;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [127:0]   mem [DEPTH];
    logic           accept, done_ok, push, pop, full;

    assign occ     = {1'b0, fifo_count} + {1'b0, in_flight};
    assign full    = (fifo_count == FW'(DEPTH));
    assign accept  = io.s_valid && io.s_ready;
    assign done_ok = io.enc_done && (in_flight != '0);
    assign pop     = io.m_valid && io.m_ready;
    assign push    = done_ok && (!full || pop);

    // key_load blocks admission in the same cycle so DRAIN sees a stable count
    assign io.s_ready = (state == RUN) && !io.key_load
                        && (occ < (FW+1)'(DEPTH));
    assign io.m_valid = (fifo_count != '0);
    assign io.m_data  = io.m_valid ? mem[rd_ptr] : '0;
    assign io.busy    = (state != IDLE) || (fifo_count != '0)
                        || (in_flight != '0);

    always_comb begin
        state_nx      = state;
        pending_nx    = pending;
        kexp_start_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (io.key_load) begin
                    kexp_start_nx = 1'b1;
                    state_nx      = KEY_CLR;
                end
            end
            KEY_CLR: begin
                if (io.key_load) pending_nx = 1'b1;
                if (!io.kexp_ready) state_nx = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (io.kexp_ready) begin
                    if (pending || io.key_load) begin
                        pending_nx    = 1'b0;
                        kexp_start_nx = 1'b1;
                        state_nx      = KEY_CLR;
                    end else begin
                        state_nx = RUN;
                    end
                end else if (io.key_load) begin
                    pending_nx = 1'b1;
                end
            end
            RUN: begin
                if (io.key_load) state_nx = DRAIN;
            end
            DRAIN: begin
                if (in_flight == '0) begin
                    kexp_start_nx = 1'b1;
                    state_nx      = KEY_CLR;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            io.kexp_start <= 1'b0;
            io.enc_valid  <= 1'b0;
            io.enc_data   <= '0;
            in_flight     <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            io.err        <= 1'b0;
            io.blk_count  <= '0;
        end else begin
            state         <= state_nx;
            pending       <= pending_nx;
            io.kexp_start <= kexp_start_nx;
            io.enc_valid  <= accept;
            if (accept) io.enc_data <= io.s_data;
            unique case ({accept, done_ok})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // a completion with nothing outstanding is a datapath fault
            if (io.enc_done && (in_flight == '0)) io.err <= 1'b1;
            if (pop) io.blk_count <= io.blk_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= io.enc_out;
    end
endmodule

// File: tb/tb_aes_stream_scheduler.sv
// Bench for aes_stream_scheduler: behavioural AES-128 key expansion and
// 11-stage pipeline beside the DUT, scoreboard on the output stream.
module tb_aes_stream_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aes_stream_scheduler_if #(.CNT_W(32)) io();

    aes_stream_scheduler dut (
        .clk(clk),
        .reset_n(reset_n),
        .io(io)
    );

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    int tests = 0;
    int fails = 0;
    logic [127:0] sb [$];
    logic [7:0]   sbox [256];
    logic [127:0] key_in, mdl_key, cur_key, mon_exp;
    logic         pipe_v [11];
    logic [127:0] pipe_d [11];
    logic         inject;
    logic [127:0] inj_data;
    int           kcnt;
    vec_t         tbl [6];

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key,
                                            input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]],
                       sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[q+4*c] = b[q+4*((c+q)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1];
                    a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    assign io.enc_done = pipe_v[10] | inject;
    assign io.enc_out  = inject ? inj_data : pipe_d[10];

    // datapath stand-ins: fixed-latency pipeline and slow key expansion
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 11; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
            kcnt          <= 0;
            io.kexp_ready <= 1'b1;
            mdl_key       <= '0;
        end else begin
            pipe_v[0] <= io.enc_valid;
            pipe_d[0] <= io.enc_valid ? aes128(mdl_key, io.enc_data) : '0;
            for (int i = 1; i < 11; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            if (io.kexp_start) begin
                io.kexp_ready <= 1'b0;
                kcnt          <= 40;
            end else if (kcnt == 1) begin
                io.kexp_ready <= 1'b1;
                mdl_key       <= key_in;
                kcnt          <= 0;
            end else if (kcnt != 0) begin
                kcnt <= kcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && io.m_valid && io.m_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: got %h, expected nothing", io.m_data);
            end else begin
                mon_exp = sb.pop_front();
                if (io.m_data !== mon_exp) begin
                    fails++;
                    $display("FAIL sb_data: got %h expected %h", io.m_data, mon_exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!io.s_ready && n < 300) begin
            cyc();
            n++;
        end
        if (!io.s_ready) timeout("wait_run");
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            cyc();
            n++;
        end
        if (sb.size() != 0) timeout("wait_drain");
        cyc();
        cyc();
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e);
        int n;
        n = 0;
        io.s_valid = 1'b1;
        io.s_data  = d;
        @(negedge clk);
        while (!io.s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!io.s_ready) timeout("send");
        else sb.push_back(e);
        cyc();
        io.s_valid = 1'b0;
    endtask

    task automatic stream(input int want, input int maxc,
                          output int acc, output int stalls);
        logic took;
        acc        = 0;
        stalls     = 0;
        io.s_valid = 1'b1;
        io.s_data  = rnd128();
        for (int c = 0; c < maxc && acc < want; c++) begin
            @(negedge clk);
            took = io.s_ready;
            if (took) begin
                sb.push_back(aes128(cur_key, io.s_data));
                acc++;
            end else begin
                stalls++;
            end
            cyc();
            if (took) io.s_data = rnd128();
        end
        io.s_valid = 1'b0;
    endtask

    initial begin
        int n, ks, acc, st, dn;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2)
                      ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        tbl[0].pt = 128'h00112233445566778899aabbccddeeff;
        tbl[0].ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tbl[1].pt = '0;
        tbl[2].pt = '1;
        for (int i = 3; i < 6; i++) tbl[i].pt = rnd128();
        for (int i = 1; i < 6; i++) tbl[i].ct = aes128(K0, tbl[i].pt);

        io.key_load = 1'b0;
        io.s_valid  = 1'b0;
        io.s_data   = '0;
        io.m_ready  = 1'b1;
        inject      = 1'b0;
        inj_data    = '0;
        key_in      = K0;
        cur_key     = '0;

        reset_n = 1'b0;
        repeat (3) cyc();
        chk("rst_s_ready", io.s_ready, 0);
        chk("rst_kexp_start", io.kexp_start, 0);
        reset_n = 1'b1;
        cyc();
        chk("rst_busy", io.busy, 0);
        chk("rst_m_valid", io.m_valid, 0);
        chk("rst_blk_count", io.blk_count, 0);
        chk("rst_err", io.err, 0);

        io.key_load = 1'b1;
        cyc();
        io.key_load = 1'b0;
        ks = 0;
        repeat (10) begin
            @(negedge clk);
            if (io.kexp_start) ks++;
        end
        chk("kexp_start_width", ks, 1);
        wait_run(n);
        chk("key_wait_long", n >= 25, 1);
        chk("run_busy", io.busy, 1);
        cur_key = K0;

        io.s_valid = 1'b1;
        io.s_data  = tbl[0].pt;
        n = 0;
        @(negedge clk);
        while (!io.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!io.s_ready) timeout("fips_accept");
        else sb.push_back(tbl[0].ct);
        cyc();
        io.s_valid = 1'b0;
        chk("enc_valid_after_accept", io.enc_valid, 1);
        chk("enc_data_after_accept", io.enc_data, tbl[0].pt);
        cyc();
        chk("enc_valid_single", io.enc_valid, 0);
        wait_drain();
        chk("blk_count_first", io.blk_count, 1);

        for (int i = 1; i < 6; i++) begin
            send(tbl[i].pt, tbl[i].ct);
            wait_drain();
            chk("blk_count_table", io.blk_count, 32'(i + 1));
        end

        stream(100, 400, acc, st);
        chk("b2b_accepted", acc, 100);
        chk("b2b_stalls", st, 0);
        wait_drain();
        chk("blk_count_b2b", io.blk_count, 106);

        io.m_ready = 1'b0;
        stream(1000, 60, acc, st);
        chk("credit_accepted", acc, 16);
        @(negedge clk);
        chk("credit_m_valid", io.m_valid, 1);
        chk("credit_blk_hold", io.blk_count, 106);
        cyc();
        io.m_ready = 1'b1;
        wait_drain();
        chk("blk_count_credit", io.blk_count, 122);
        stream(20, 200, acc, st);
        chk("credit_resume", acc, 20);
        wait_drain();
        chk("blk_count_resume", io.blk_count, 142);

        stream(5, 50, acc, st);
        key_in      = K1;
        io.key_load = 1'b1;
        io.s_valid  = 1'b1;
        io.s_data   = rnd128();
        @(negedge clk);
        chk("keyload_s_ready", io.s_ready, 0);
        cyc();
        io.key_load = 1'b0;
        io.s_valid  = 1'b0;
        dn = 0;
        n  = 0;
        while (n < 100) begin
            @(negedge clk);
            if (io.kexp_start) break;
            if (io.enc_done) dn++;
            n++;
        end
        if (n == 100) timeout("drain_kexp_start");
        chk("drain_done_before_start", dn, 5);
        wait_run(n);
        cur_key = K1;
        send(128'h3243f6a8885a308d313198a2e0370734,
             128'h3925841d02dc09fbdc118597196a0b32);
        wait_drain();
        chk("blk_count_rekey", io.blk_count, 148);

        inject   = 1'b1;
        inj_data = rnd128();
        cyc();
        inject = 1'b0;
        chk("err_set", io.err, 1);
        chk("err_no_push", io.m_valid, 0);
        repeat (5) cyc();
        chk("err_sticky", io.err, 1);
        chk("err_blk_count", io.blk_count, 148);

        stream(3, 20, acc, st);
        repeat (2) cyc();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", io.busy, 0);
        chk("mid_rst_enc_valid", io.enc_valid, 0);
        chk("mid_rst_enc_data", io.enc_data, 0);
        chk("mid_rst_m_valid", io.m_valid, 0);
        chk("mid_rst_m_data", io.m_data, 0);
        chk("mid_rst_blk_count", io.blk_count, 0);
        chk("mid_rst_err", io.err, 0);
        chk("mid_rst_s_ready", io.s_ready, 0);
        sb.delete();
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (20) cyc();
        chk("post_rst_err", io.err, 0);
        chk("post_rst_busy", io.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
